// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//   Upstream APB requester. Takes one command at a time on a valid/ready
//   command interface, runs the APB SETUP/ACCESS sequence, waits for pready
//   and returns read data (or write completion) on a valid/ready response
//   interface. At most one transfer is outstanding.
//
//   Build option: define APB_TIMEOUT_EN to abort an ACCESS phase that has
//   waited TIMEOUT_CYCLES cycles without pready (response flagged rsp_err).
//   Without it ACCESS waits indefinitely and rsp_err is constant 0.
//
// Ports
//   pclk, PRESETn        clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready  command handshake; cmd_write/cmd_addr/cmd_wdata
//   rsp_valid/rsp_ready  response handshake; rsp_rdata, rsp_err
//   psel, penable, pwrite, paddr, pwdata   APB request outputs (registered)
//   prdata, pready                        APB slave returns
module apb_master_bridge #(
   parameter int unsigned ADDR_WIDTH     = 10,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  pclk,
   input  logic                  PRESETn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [DATA_WIDTH-1:0] pwdata,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pready
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("apb_master_bridge: TIMEOUT_CYCLES must be >= 1");
   end

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } state_t;

   state_t state, state_nxt;
   logic   cmd_fire;
   logic   access_done;
   logic   access_tmo;

   assign cmd_ready   = (state == IDLE);
   assign cmd_fire    = cmd_valid & cmd_ready;
   assign access_done = (state == ACCESS) & pready;

`ifdef APB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] tmo_cnt;

   // tmo_cnt holds the number of completed wait cycles, so the limit is hit
   // in the ACCESS cycle whose own wait would bring the count to the limit.
   // pready in that same cycle takes priority (access_done path).
   assign access_tmo = (state == ACCESS) & ~pready &
                       (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge pclk or negedge PRESETn) begin
      if (!PRESETn) begin
         tmo_cnt <= '0;
      end else if ((state_nxt == ACCESS) && (state != ACCESS)) begin
         tmo_cnt <= '0;
      end else if ((state == ACCESS) && !pready) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   always_ff @(posedge pclk or negedge PRESETn) begin
      if (!PRESETn) begin
         rsp_err <= 1'b0;
      end else if (access_done) begin
         rsp_err <= 1'b0;
      end else if (access_tmo) begin
         rsp_err <= 1'b1;
      end
   end
`else
   assign access_tmo = 1'b0;
   assign rsp_err    = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_valid)                  state_nxt = SETUP;
         SETUP:                                   state_nxt = ACCESS;
         ACCESS:  if (access_done || access_tmo)  state_nxt = RESP;
         RESP:    if (rsp_ready)                  state_nxt = IDLE;
         default:                                 state_nxt = IDLE;
      endcase
   end

   // APB strobes and rsp_valid are registered from the next state so they
   // come straight off flops and line up with the state they describe.
   always_ff @(posedge pclk or negedge PRESETn) begin
      if (!PRESETn) begin
         state     <= IDLE;
         psel      <= 1'b0;
         penable   <= 1'b0;
         rsp_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         psel      <= (state_nxt == SETUP) || (state_nxt == ACCESS);
         penable   <= (state_nxt == ACCESS);
         rsp_valid <= (state_nxt == RESP);
      end
   end

   always_ff @(posedge pclk or negedge PRESETn) begin
      if (!PRESETn) begin
         pwrite <= 1'b0;
         paddr  <= '0;
         pwdata <= '0;
      end else if (cmd_fire) begin
         pwrite <= cmd_write;
         paddr  <= cmd_addr;
         pwdata <= cmd_wdata;
      end
   end

   always_ff @(posedge pclk or negedge PRESETn) begin
      if (!PRESETn) begin
         rsp_rdata <= '0;
      end else if (access_done) begin
         rsp_rdata <= pwrite ? '0 : prdata;
      end else if (access_tmo) begin
         rsp_rdata <= '0;
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
//   Self-checking bench for apb_master_bridge. An APB memory slave model
//   with programmable wait states answers the bridge; expected responses are
//   queued when a command is accepted and compared when the response
//   handshake happens.
module tb_apb_master_bridge;

   localparam int unsigned AW = 10;
   localparam int unsigned DW = 32;

   logic          pclk = 1'b0;
   logic          PRESETn = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic [DW-1:0] prdata;
   logic          pready;

   apb_master_bridge #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .pclk     (pclk),
      .PRESETn  (PRESETn),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_write(cmd_write),
      .cmd_addr (cmd_addr),
      .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata),
      .rsp_err  (rsp_err),
      .psel     (psel),
      .penable  (penable),
      .pwrite   (pwrite),
      .paddr    (paddr),
      .pwdata   (pwdata),
      .prdata   (prdata),
      .pready   (pready)
   );

   always #5 pclk = ~pclk;

   int unsigned checks = 0;
   int unsigned errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- APB slave model ----------------
   logic [DW-1:0] mem [0:(1<<AW)-1];
   int unsigned   wait_cfg = 0;
   bit            never_ready = 1'b0;
   int unsigned   wcnt = 0;

   always_comb begin
      pready = psel && penable && !never_ready && (wcnt >= wait_cfg);
      // Garbage on prdata during writes so a write response leaking it shows up.
      prdata = pwrite ? 32'hBAD0_BAD0 : mem[paddr];
   end

   always @(posedge pclk) begin
      if (psel && penable && !pready) wcnt <= wcnt + 1;
      else                            wcnt <= 0;
      if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   exp_t          sb[$];
   logic [AW-1:0] exp_paddr  = '0;
   logic          exp_pwrite = 1'b0;
   logic [DW-1:0] exp_pwdata = '0;

   always @(negedge pclk) begin
      if (PRESETn && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            check("rsp_unexpected", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_err", rsp_err, e.err);
         end
      end
      if (PRESETn && psel) begin
         check("paddr_hold", paddr, exp_paddr);
         check("pwrite_hold", pwrite, exp_pwrite);
         check("pwdata_hold", pwdata, exp_pwdata);
      end
   end

   // ---------------- stimulus helpers ----------------
   // Present a command and wait for the accepting edge. Returns at
   // acceptance edge + 1 (SETUP cycle). keep leaves cmd_valid asserted.
   task automatic accept(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] erd, input bit eerr, input bit keep);
      bit done = 1'b0;
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      for (int i = 0; i < 200 && !done; i++) begin
         if (cmd_ready) begin
            check("accept_in_idle_psel", psel, 1'b0);
            @(posedge pclk);
            #1;
            sb.push_back('{rdata: erd, err: eerr});
            exp_paddr  = a;
            exp_pwrite = w;
            exp_pwdata = d;
            done = 1'b1;
         end else begin
            @(posedge pclk);
            #1;
         end
      end
      if (!done) check("accept_timeout", 64'd0, 64'd1);
      if (!keep) cmd_valid = 1'b0;
   endtask

   // Zero-wait transfer with cycle-exact strobe/latency checks.
   task automatic xfer_zw(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW-1:0] erd);
      accept(w, a, d, erd, 1'b0, 1'b0);
      check("setup_psel", psel, 1'b1);
      check("setup_penable", penable, 1'b0);
      @(posedge pclk); #1;
      check("access_psel", psel, 1'b1);
      check("access_penable", penable, 1'b1);
      @(posedge pclk); #1;
      check("resp_valid_n3", rsp_valid, 1'b1);
      check("resp_psel", psel, 1'b0);
      check("resp_cmd_ready", cmd_ready, 1'b0);
      @(posedge pclk); #1;
      check("back_idle", cmd_ready, 1'b1);
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         if (sb.size() == 0 && !rsp_valid && cmd_ready) done = 1'b1;
         else begin @(posedge pclk); #1; end
      end
      if (!done) check("drain_timeout", 64'd0, 64'd1);
   endtask

   task automatic do_reset();
      PRESETn = 1'b0;
      #1;
      sb.delete();
      repeat (2) @(posedge pclk);
      #1;
      PRESETn = 1'b1;
      @(posedge pclk); #1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bit            seen;
      logic [DW-1:0] held;
      int unsigned   n;

      for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
      mem[10'h3FF] = 32'h1234_5678;

      // Reset state
      #2;
      check("rst_psel", psel, 1'b0);
      check("rst_penable", penable, 1'b0);
      check("rst_pwrite", pwrite, 1'b0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_err", rsp_err, 1'b0);
      check("rst_paddr", paddr, '0);
      check("rst_pwdata", pwdata, '0);
      check("rst_rsp_rdata", rsp_rdata, '0);
      check("rst_cmd_ready", cmd_ready, 1'b1);
      repeat (2) @(posedge pclk);
      #1;
      PRESETn = 1'b1;
      @(posedge pclk); #1;

      // Write then read back through the slave
      xfer_zw(1'b1, 10'h004, 32'hDEAD_BEEF, 32'h0);
      xfer_zw(1'b0, 10'h004, 32'h0, 32'hDEAD_BEEF);

      // Wait-state slave: 3 extra ACCESS cycles
      wait_cfg = 3;
      accept(1'b0, 10'h3FF, 32'h0, 32'h1234_5678, 1'b0, 1'b0);
      check("ws_setup_penable", penable, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(posedge pclk); #1;
         check("ws_psel", psel, 1'b1);
         check("ws_penable", penable, 1'b1);
         check("ws_paddr", paddr, 10'h3FF);
         check("ws_no_rsp", rsp_valid, 1'b0);
      end
      @(posedge pclk); #1;
      check("ws_rsp_valid", rsp_valid, 1'b1);
      wait_cfg = 0;
      drain();

      // Response back-pressure
      rsp_ready = 1'b0;
      accept(1'b1, 10'h008, 32'hA5A5_5A5A, 32'h0, 1'b0, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge pclk); #1;
         seen = rsp_valid;
      end
      check("bp_rsp_seen", seen, 1'b1);
      rsp_ready = 1'b1;
      drain();
      rsp_ready = 1'b0;
      accept(1'b0, 10'h008, 32'h0, 32'hA5A5_5A5A, 1'b0, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge pclk); #1;
         seen = rsp_valid;
      end
      check("bp_rsp_seen2", seen, 1'b1);
      held = rsp_rdata;
      check("bp_rdata_val", held, 32'hA5A5_5A5A);
      for (int i = 0; i < 5; i++) begin
         @(posedge pclk); #1;
         check("bp_valid_hold", rsp_valid, 1'b1);
         check("bp_rdata_hold", rsp_rdata, held);
         check("bp_cmd_ready", cmd_ready, 1'b0);
      end
      rsp_ready = 1'b1;
      @(posedge pclk); #1;
      check("bp_release_idle", cmd_ready, 1'b1);
      check("bp_release_valid", rsp_valid, 1'b0);

      // cmd_valid held continuously across three commands
      accept(1'b1, 10'h010, 32'h1111_1111, 32'h0, 1'b0, 1'b1);
      accept(1'b1, 10'h020, 32'h2222_2222, 32'h0, 1'b0, 1'b1);
      accept(1'b0, 10'h010, 32'h0, 32'h1111_1111, 1'b0, 1'b0);
      drain();
      accept(1'b0, 10'h020, 32'h0, 32'h2222_2222, 1'b0, 1'b0);
      drain();

      // Reset during ACCESS of a read
      never_ready = 1'b1;
      accept(1'b0, 10'h004, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
      @(posedge pclk); #1;
      check("mid_access_penable", penable, 1'b1);
      PRESETn = 1'b0;
      #1;
      sb.delete();
      check("mid_rst_psel", psel, 1'b0);
      check("mid_rst_penable", penable, 1'b0);
      check("mid_rst_rsp_valid", rsp_valid, 1'b0);
      never_ready = 1'b0;
      repeat (2) @(posedge pclk);
      #1;
      PRESETn = 1'b1;
      @(posedge pclk); #1;
      check("post_rst_cmd_ready", cmd_ready, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge pclk); #1;
         if (rsp_valid || psel) seen = 1'b1;
      end
      check("post_rst_quiet", seen, 1'b0);

      // Slave that never answers
      never_ready = 1'b1;
`ifdef APB_TIMEOUT_EN
      accept(1'b0, 10'h004, 32'h0, 32'h0, 1'b1, 1'b0);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge pclk); #1;
         if (penable) n++;
         else break;
      end
      check("tmo_access_cycles", n, 16);
      check("tmo_rsp_valid", rsp_valid, 1'b1);
      check("tmo_psel", psel, 1'b0);
      never_ready = 1'b0;
      drain();
`else
      accept(1'b0, 10'h004, 32'h0, 32'h0, 1'b0, 1'b0);
      n = 0;
      seen = 1'b0;
      for (int i = 0; i < 110; i++) begin
         @(posedge pclk); #1;
         if (penable && psel) n++;
         if (rsp_err || rsp_valid) seen = 1'b1;
      end
      check("notmo_access_cycles", n, 110);
      check("notmo_err_or_rsp", seen, 1'b0);
      never_ready = 1'b0;
      do_reset();
`endif

      // Clean transfer after recovery
      xfer_zw(1'b0, 10'h3FF, 32'h0, 32'h1234_5678);
      drain();
      check("sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream requester for the APB memory slave. Accepts one command at a time on a valid/ready interface and runs the APB SETUP/ACCESS sequence for it.
- Waits for pready, then returns read data (or write completion) on a valid/ready response interface.
- Sits between the testbench/host command source and the APB slave. At most one transfer is outstanding.

Parameters:
- ADDR_WIDTH, 10, APB address width; matches the slave's address width.
- DATA_WIDTH, 32, APB read/write data width.
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit. Only used when APB_TIMEOUT_EN is defined. Must be >= 1.

Ports:
- pclk  input  1  APB clock; all logic is on the rising edge.
- PRESETn  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  bridge can accept a command.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_WIDTH  target address.
- cmd_wdata  input  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes.
- rsp_err  output  1  transfer aborted by timeout.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  APB direction.
- paddr  output  ADDR_WIDTH  APB address.
- pwdata  output  DATA_WIDTH  APB write data.
- prdata  input  DATA_WIDTH  APB read data.
- pready  input  1  APB ready.

Behaviour:
- Reset (async assert on PRESETn low, sync release):
  - State goes to IDLE.
  - psel, penable, pwrite, rsp_valid, rsp_err = 0.
  - paddr, pwdata, rsp_rdata = 0.
  - Timeout counter = 0.
  - Reset mid-transfer abandons the transfer; no response is produced.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1. psel = penable = 0.
  - On cmd_valid & cmd_ready: register cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata; go to SETUP.
- SETUP: psel = 1, penable = 0. Unconditionally go to ACCESS next cycle.
- ACCESS:
  - psel = 1, penable = 1.
  - If pready is sampled 1: capture prdata into rsp_rdata for reads, or load 0 for writes; rsp_err = 0; go to RESP.
  - Otherwise stay in ACCESS with all APB outputs stable.
- RESP:
  - rsp_valid = 1. psel = penable = 0. cmd_ready = 0.
  - On rsp_ready go to IDLE; rsp_valid drops the following cycle.
  - rsp_rdata and rsp_err hold stable while rsp_valid is 1 and rsp_ready is 0.
- cmd_ready is 0 in every state except IDLE. cmd_valid asserted outside IDLE is not accepted and must be held by the source.
- paddr, pwrite and pwdata change only on command acceptance and hold their last value otherwise.
- psel and penable are registered outputs, glitch-free.
- Latency with a zero-wait slave:
  - Command accepted at edge N.
  - SETUP during cycle N+1.
  - ACCESS during N+2 (pready sampled at the end of N+2).
  - rsp_valid high from cycle N+3.
  - Minimum 4 cycles per transfer when rsp_ready is held high.
- Simultaneous pready and reset: reset wins.
- pready is ignored outside ACCESS.
- prdata is sampled only in ACCESS with pready = 1 and pwrite = 0.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle in which pready = 0.
  - When the count reaches TIMEOUT_CYCLES with pready still 0: drop psel/penable, go to RESP with rsp_err = 1 and rsp_rdata = 0.
  - If pready = 1 on the same cycle the limit is reached, pready wins: normal completion, rsp_err = 0.
- Not defined:
  - No counter.
  - ACCESS waits indefinitely for pready.
  - rsp_err is tied to 0.

Test Plan:
- Write 0xDEADBEEF to addr 0x004, then read 0x004 against the APB memory slave:
  - Expect psel 1 for 2 cycles per transfer, penable 1 in the second.
  - Write response: rsp_rdata = 0, rsp_err = 0.
  - Read response: rsp_rdata = 0xDEADBEEF, rsp_valid 3 cycles after acceptance.
- Slave stub holds pready low for 3 ACCESS cycles on a read of 0x3FF returning 0x12345678:
  - paddr, psel and penable stay stable for 4 ACCESS cycles.
  - Response rdata = 0x12345678.
- Hold rsp_ready low for 5 cycles after rsp_valid:
  - rsp_valid and rsp_rdata stay stable.
  - cmd_ready stays 0.
  - Bridge returns to IDLE one cycle after rsp_ready rises.
- Hold cmd_valid high continuously with 3 different commands:
  - Each is accepted only in IDLE.
  - APB transfers are issued in order, with no overlap of psel.
- Assert PRESETn low during ACCESS of a read:
  - psel, penable and rsp_valid go to 0 immediately.
  - After release the bridge is in IDLE with cmd_ready = 1 and no response emitted.
- With APB_TIMEOUT_EN and TIMEOUT_CYCLES = 16, pready never asserted:
  - Exit ACCESS after 16 cycles.
  - rsp_err = 1, rsp_rdata = 0.
- Same stimulus without APB_TIMEOUT_EN: stay in ACCESS for 100+ cycles with rsp_err constant 0.
